// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, opcode constants and fetch defaults.
package cpu_pkg;

    localparam int unsigned INST_W = 32;
    localparam int unsigned OP_W   = 6;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [OP_W-1:0] OP_J    = 6'b000010;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_BNE  = 6'b000101;
    localparam logic [OP_W-1:0] OP_BGTZ = 6'b000111;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    function automatic logic [OP_W-1:0] inst_opcode(input logic [INST_W-1:0] inst);
        return inst[31:26];
    endfunction

endpackage

// File: rtl/ifetch_npc.sv
// Next-PC computation: pc+4, sign-extended branch target, and (with IFETCH_JUMP_EN)
// the local j-instruction target, which overrides nPC_sel.
module ifetch_npc
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [INST_W-1:0] inst,
    input  logic              nPC_sel,
    input  logic [15:0]       imm16,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] next_pc
);

    localparam int unsigned OFF_EXT_W = ADDR_W - 18;

    logic [ADDR_W-1:0] br_offset;
    logic [ADDR_W-1:0] br_target;
    logic              is_jump;
    logic [ADDR_W-1:0] jump_target;

`ifdef IFETCH_JUMP_EN
    assign is_jump     = (inst_opcode(inst) == OP_J);
    assign jump_target = {pc_plus4[ADDR_W-1:28], inst[25:0], 2'b00};
`else
    logic unused_inst;
    assign is_jump     = 1'b0;
    assign jump_target = '0;
    assign unused_inst = ^inst;
`endif

    // All adds wrap modulo 2^ADDR_W; a word offset of -1 lands back on pc.
    always_comb begin
        pc_plus4  = pc + ADDR_W'(4);
        br_offset = {{OFF_EXT_W{imm16[15]}}, imm16, 2'b00};
        br_target = pc_plus4 + br_offset;
        next_pc   = nPC_sel ? br_target : pc_plus4;
        if (is_jump) begin
            next_pc = jump_target;
        end
    end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack handshake and holds
// inst stable until the datapath retires it. Optional jump decode: IFETCH_JUMP_EN.
module ifetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    input  logic              advance,
    input  logic              nPC_sel,
    input  logic [15:0]       imm16,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4
);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] next_pc;

    ifetch_npc #(
        .ADDR_W (ADDR_W)
    ) u_npc (
        .pc       (pc_q),
        .inst     (inst_q),
        .nPC_sel  (nPC_sel),
        .imm16    (imm16),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

    // imem_req is registered: it reflects the state being entered, so it is high
    // for every cycle spent in FETCH and low in BOOT/HOLD.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        imem_req_d   = 1'b0;
        case (state_q)
            BOOT: begin
                state_d    = FETCH;
                imem_req_d = 1'b1;
            end
            FETCH: begin
                if (imem_ack) begin
                    inst_d       = imem_rdata;
                    inst_valid_d = 1'b1;
                    state_d      = HOLD;
                end else begin
                    imem_req_d = 1'b1;
                end
            end
            HOLD: begin
                if (advance) begin
                    pc_d         = next_pc;
                    inst_valid_d = 1'b0;
                    state_d      = FETCH;
                    imem_req_d   = 1'b1;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            imem_req_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            imem_req_q   <= imem_req_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;

    // Address must be word aligned and held stable while a request is pending.
    a_pc_aligned : assert property (@(posedge clk) disable iff (rst)
        pc_q[1:0] == 2'b00);
    a_req_stable : assert property (@(posedge clk) disable iff (rst)
        (imem_req_q && !imem_ack) |=> (imem_req_q && $stable(pc_q)));

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: memory responder plus an address scoreboard.
module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        advance;
    logic        nPC_sel;
    logic [15:0] imm16;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] cur_pc;

`ifdef IFETCH_JUMP_EN
    localparam logic [31:0] J_NEXT = 32'h0000_0400;
`else
    localparam logic [31:0] J_NEXT = 32'h0000_0040;
`endif

    ifetch_unit #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .inst       (inst),
        .inst_valid (inst_valid),
        .advance    (advance),
        .nPC_sel    (nPC_sel),
        .imm16      (imm16),
        .pc         (pc),
        .pc_plus4   (pc_plus4)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Bounded wait for a request, then compare its address against the scoreboard.
    task automatic expect_req();
        int          n;
        logic [31:0] e;
        n = 0;
        while (imem_req !== 1'b1 && n < 16) begin
            tick();
            n++;
        end
        check("req_seen", 32'(imem_req), 32'd1);
        if (exp_addr_q.size() == 0) begin
            check("sb_underflow", 32'(exp_addr_q.size()), 32'd1);
        end else begin
            e = exp_addr_q.pop_front();
            check("fetch_addr", imem_addr, e);
            check("pc_eq_addr", pc, e);
            cur_pc = e;
        end
    endtask

    task automatic serve_fetch(input int wait_n, input logic [31:0] data, input logic adv_noise);
        expect_req();
        for (int i = 0; i < wait_n; i++) begin
            if (adv_noise) begin
                advance = 1'b1;
                nPC_sel = 1'b1;
                imm16   = 16'h7FFF;
            end
            tick();
            check("req_hold", 32'(imem_req), 32'd1);
            check("pc_stable", pc, cur_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = data;
        if (adv_noise) begin
            advance = 1'b1;
            nPC_sel = 1'b1;
            imm16   = 16'h7FFF;
        end
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        advance    = 1'b0;
        nPC_sel    = 1'b0;
        check("inst", inst, data);
        check("inst_valid", 32'(inst_valid), 32'd1);
        check("req_drop", 32'(imem_req), 32'd0);
        check("pc_after_fetch", pc, cur_pc);
    endtask

    task automatic advance_to(input logic sel, input logic [15:0] imm, input logic [31:0] exp_next);
        exp_addr_q.push_back(exp_next);
        advance = 1'b1;
        nPC_sel = sel;
        imm16   = imm;
        tick();
        advance = 1'b0;
        nPC_sel = 1'($urandom);
        imm16   = 16'($urandom);
        check("valid_clr", 32'(inst_valid), 32'd0);
    endtask

    initial begin
        rst        = 1'b1;
        advance    = 1'b0;
        nPC_sel    = 1'b0;
        imm16      = 16'h0000;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        cur_pc     = 32'h0;

        tick();
        tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_pc", pc, 32'h0);

        // BOOT cycle, with a stray ack that must be ignored.
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        imem_ack = 1'b0;
        check("boot_req", 32'(imem_req), 32'd1);
        check("boot_addr", imem_addr, 32'h0);
        check("boot_ack_inst", inst, 32'h0);
        check("boot_ack_valid", 32'(inst_valid), 32'd0);
        exp_addr_q.push_back(32'h0);
        serve_fetch(3, 32'h2008_0005, 1'b0);

        // Acks and branch noise during HOLD leave everything untouched.
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0001;
        nPC_sel    = 1'b1;
        imm16      = 16'h1234;
        tick();
        imem_ack = 1'b0;
        tick();
        check("hold_inst", inst, 32'h2008_0005);
        check("hold_valid", 32'(inst_valid), 32'd1);
        check("hold_pc", pc, 32'h0);
        check("hold_req", 32'(imem_req), 32'd0);

        advance_to(1'b1, 16'h0003, 32'h0000_0010);
        serve_fetch(0, 32'h8C22_0004, 1'b0);
        advance_to(1'b0, 16'h0000, 32'h0000_0014);
        serve_fetch(2, 32'h0043_2020, 1'b0);
        check("pc_plus4_seq", pc_plus4, 32'h0000_0018);
        advance_to(1'b1, 16'h000A, 32'h0000_0040);
        serve_fetch(1, 32'h1022_0003, 1'b0);
        advance_to(1'b1, 16'h0003, 32'h0000_0050);
        serve_fetch(0, 32'hAC22_0008, 1'b0);
        advance_to(1'b1, 16'hFFFB, 32'h0000_0040);
        serve_fetch(1, 32'h1400_FFFE, 1'b0);
        advance_to(1'b1, 16'hFFFE, 32'h0000_003C);
        serve_fetch(2, 32'h2108_0001, 1'b0);
        advance_to(1'b1, 16'hFFFF, 32'h0000_003C);
        serve_fetch(1, 32'h0800_0100, 1'b0);

        // j instruction, then a fetch with advance held high throughout.
        advance_to(1'b0, 16'h0000, J_NEXT);
        serve_fetch(3, 32'h0000_0000, 1'b1);

        // Reset while a request is outstanding.
        advance_to(1'b0, 16'h0000, J_NEXT + 32'd4);
        expect_req();
        rst = 1'b1;
        tick();
        check("midrst_req", 32'(imem_req), 32'd0);
        check("midrst_pc", pc, 32'h0);
        check("midrst_valid", 32'(inst_valid), 32'd0);
        rst = 1'b0;
        tick();
        check("reboot_req", 32'(imem_req), 32'd1);
        exp_addr_q.push_back(32'h0);
        serve_fetch(2, 32'h2009_0007, 1'b0);

        // Wrap backwards through zero, then forwards again.
        advance_to(1'b1, 16'hFFFE, 32'hFFFF_FFFC);
        serve_fetch(1, 32'h0000_0020, 1'b0);
        check("wrap_pc_plus4", pc_plus4, 32'h0);
        advance_to(1'b0, 16'h0000, 32'h0000_0000);
        serve_fetch(0, 32'h0000_0021, 1'b0);

        check("sb_drained", 32'(exp_addr_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
